sram_host_ctrl: RTL and testbench

//   Host-side controller for the single-port, clocked, tri-state SRAM macro.

---
 rtl/sram_host_ctrl.sv | 140 ++++++++++++++
 tb/tb_sram_host_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_host_ctrl.sv
// Host-side controller for a single-port clocked tri-state SRAM: turns a
// valid/ready request stream into registered CSb/WEb/OEb/ADDR/DATA bus cycles.
module sram_host_ctrl #(
  parameter int DATA_WIDTH = 3,
  parameter int ADDR_WIDTH = 4,
  parameter int READ_WAIT  = 1
) (
  input  logic                  clk,
  input  logic                  RSTb,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  inout  wire  [DATA_WIDTH-1:0] DATA,
  output logic [ADDR_WIDTH-1:0] ADDR,
  output logic                  CSb,
  output logic                  WEb,
  output logic                  OEb,
  output logic [1:0]            dbg_state_o
);

  // Handshakes: a transfer happens on a posedge where valid && ready are both
  // high; valid never depends on ready, and the payload is held while valid.

  localparam int CW = (READ_WAIT > 1) ? $clog2(READ_WAIT + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  req_ready_q, req_ready_d;
  logic                  cs_b_q, cs_b_d;
  logic                  we_b_q, we_b_d;
  logic                  oe_b_q, oe_b_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  always_comb begin
    state_d     = state_q;
    cs_b_d      = cs_b_q;
    we_b_d      = we_b_q;
    oe_b_d      = oe_b_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rdata_d     = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cs_b_d  = 1'b0;
          if (req_we) begin
            we_b_d  = 1'b0;
            state_d = S_WRITE;
          end else begin
            oe_b_d  = 1'b0;
            cnt_d   = CW'(READ_WAIT);
            state_d = S_READ;
          end
        end
      end
      S_WRITE: begin
        cs_b_d  = 1'b1;
        we_b_d  = 1'b1;
        state_d = S_IDLE;
      end
      S_READ: begin
        // DATA is sampled on the edge that also releases the bus.
        if (cnt_q == '0) begin
          rdata_d     = DATA;
          rsp_valid_d = 1'b1;
          cs_b_d      = 1'b1;
          oe_b_d      = 1'b1;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    req_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!RSTb) begin
      state_q     <= S_IDLE;
      req_ready_q <= 1'b0;
      cs_b_q      <= 1'b1;
      we_b_q      <= 1'b1;
      oe_b_q      <= 1'b1;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      cs_b_q      <= cs_b_d;
      we_b_q      <= we_b_d;
      oe_b_q      <= oe_b_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
    end
  end

  // Driving only while WEb is low keeps the bus contention-free by construction.
  assign DATA        = we_b_q ? {DATA_WIDTH{1'bz}} : wdata_q;
  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rdata_q;
  assign ADDR        = addr_q;
  assign CSb         = cs_b_q;
  assign WEb         = we_b_q;
  assign OEb         = oe_b_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sram_host_ctrl.sv
// Bench for sram_host_ctrl: behavioural SRAM on the tri-state bus, random and
// directed requests, expected read data queued at issue and checked by a monitor.
module tb_sram_host_ctrl;

  localparam int DW = 3;
  localparam int AW = 4;
  localparam int RW = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          RSTb;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  wire  [DW-1:0] data_bus;
  logic [AW-1:0] ADDR;
  logic          CSb, WEb, OEb;
  logic [1:0]    dbg_state;

  sram_host_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_WAIT(RW)) dut (
    .clk(clk), .RSTb(RSTb),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .DATA(data_bus), .ADDR(ADDR), .CSb(CSb), .WEb(WEb), .OEb(OEb),
    .dbg_state_o(dbg_state)
  );

  // ---------------- SRAM model ----------------
  logic [DW-1:0] sram_mem [1<<AW];
  logic [DW-1:0] sram_q;
  always @(posedge clk) begin
    if (!CSb && !WEb) sram_mem[ADDR] <= data_bus;
    if (!CSb && WEb)  sram_q <= sram_mem[ADDR];
  end
  assign data_bus = (!CSb && !OEb && WEb) ? sram_q : {DW{1'bz}};

  // ---------------- reference model / scoreboard ----------------
  logic [DW-1:0] model_mem [1<<AW];
  logic          written   [1<<AW];
  logic [DW-1:0] exp_q [$];
  int            acc_q [$];
  int            total = 0;
  int            bad   = 0;
  int            cyc   = 0;
  logic          rst_edge;
  logic          mon_en = 1'b0;
  int            rsp_mode = 0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_edge <= !RSTb;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) begin
      chk("req_ready_timeout", 0, 1);
      req_valid = 1'b0;
      return;
    end
    // Accepted on the coming posedge.
    if (we) begin
      model_mem[a] = d;
      written[a]   = 1'b1;
    end else begin
      exp_q.push_back(model_mem[a]);
      acc_q.push_back(cyc + 1);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (we) begin
      chk("wr_bus_ctl", {CSb, WEb, OEb}, 3'b001);
      chk("wr_addr", ADDR, a);
      chk("wr_data", data_bus, d);
    end else begin
      chk("rd_bus_ctl", {CSb, WEb, OEb}, 3'b010);
      chk("rd_addr", ADDR, a);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      case (rsp_mode)
        0:       rsp_ready = 1'b1;
        1:       rsp_ready = ($urandom_range(0, 2) != 0);
        default: rsp_ready = 1'b0;
      endcase
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic          prev_valid = 1'b0;
    logic          prev_ready = 1'b0;
    logic [DW-1:0] prev_rdata = '0;
    int            oe_run = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("bus_contend", (WEb === 1'b0 && OEb === 1'b0), 0);
        chk("ctl_known", $isunknown({CSb, WEb, OEb}), 0);
        if (WEb === 1'b1 && OEb === 1'b1) chk("data_z", (data_bus === {DW{1'bz}}), 1);
        if (!rst_edge) chk("req_ready_phase", req_ready, (CSb && !rsp_valid));
        if (!OEb) oe_run++;
        else if (oe_run != 0) begin
          if (!rst_edge) chk("oe_low_len", oe_run, RW + 1);
          oe_run = 0;
        end
        if (rsp_valid && !prev_valid) begin
          if (acc_q.size() == 0) chk("rsp_spurious", 1, 0);
          else chk("rsp_latency", cyc - acc_q[0], RW + 1);
        end
        if (rsp_valid && prev_valid && !prev_ready) begin
          chk("rsp_hold", rsp_rdata, prev_rdata);
          chk("stall_bus_idle", {CSb, WEb, OEb}, 3'b111);
        end
        if (rsp_valid && rsp_ready) begin
          if (exp_q.size() == 0) chk("rsp_unexpected", 1, 0);
          else begin
            chk("rdata", rsp_rdata, exp_q.pop_front());
            void'(acc_q.pop_front());
          end
        end
      end
      prev_valid = rsp_valid;
      prev_ready = rsp_ready;
      prev_rdata = rsp_rdata;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    logic [AW-1:0] a;
    for (int i = 0; i < (1 << AW); i++) written[i] = 1'b0;
    RSTb = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_bus_ctl", {CSb, WEb, OEb}, 3'b111);
    chk("rst_addr", ADDR, 0);
    chk("rst_data_z", (data_bus === {DW{1'bz}}), 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    RSTb = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", req_ready, 1);
    mon_en = 1'b1;

    // Single write then read back.
    send(1'b1, 4'h5, 3'b101);
    send(1'b0, 4'h5, 3'b000);
    drain();

    // Fill every address with addr[2:0], then read all back.
    for (int i = 0; i < (1 << AW); i++) begin
      a = AW'(i);
      send(1'b1, a, a[DW-1:0]);
    end
    for (int i = 0; i < (1 << AW); i++) send(1'b0, AW'(i), '0);
    drain();

    // Response stall: consumer holds off for several cycles.
    rsp_mode = 2;
    @(posedge clk); #1;
    send(1'b0, 4'h3, '0);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("stall_rsp_seen", rsp_valid, 1);
    repeat (5) @(posedge clk);
    #1;
    chk("stall_valid", rsp_valid, 1);
    chk("stall_req_ready", req_ready, 0);
    rsp_mode = 0;
    drain();

    // Reset during the second READ cycle discards the response.
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'h9;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rstmid_read_issued", {CSb, OEb}, 2'b00);
    @(posedge clk); #1;
    RSTb = 1'b0;
    @(posedge clk); #1;
    chk("rstmid_bus_ctl", {CSb, WEb, OEb}, 3'b111);
    chk("rstmid_data_z", (data_bus === {DW{1'bz}}), 1);
    chk("rstmid_rsp_valid", rsp_valid, 0);
    chk("rstmid_req_ready", req_ready, 0);
    RSTb = 1'b1;
    @(posedge clk); #1;
    chk("rstmid_ready_back", req_ready, 1);
    send(1'b1, 4'h9, 3'b110);
    send(1'b0, 4'h9, '0);
    drain();

    // Random mix with random response back-pressure.
    rsp_mode = 1;
    for (int i = 0; i < 200; i++) begin
      a = AW'($urandom_range(0, (1 << AW) - 1));
      if ($urandom_range(0, 1) == 1 || !written[a]) send(1'b1, a, DW'($urandom_range(0, (1 << DW) - 1)));
      else send(1'b0, a, '0);
    end
    rsp_mode = 0;
    drain();
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
